reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised multi-read-port register file with an integrated per-register busy scoreboard.
//  Sits in the decode stage of the ARM core.
//  Serves NUM_RD asynchronous reads and one synchronous write, and returns the live PC for reads of PC_IDX.
//  Tracks in-flight producers so decode can stall on RAW hazards.
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  16  number of architectural registers (>=2)
//  NUM_RD    2   number of read ports (1..4)
//  PC_IDX    15  index returned from pc_in; never stored, never busy
//  ADDR_W    $clog2(NUM_REGS)  derived; do not override
// PORTS
//  clk          in   1               clock; all state updates on rising edge
//  rst_n        in   1               asynchronous, active-low reset
//  wr_en        in   1               write enable
//  wr_addr      in   ADDR_W          write address
//  wr_data      in   DATA_W          write data
//  rd_addr      in   NUM_RD*ADDR_W   read addresses, port i = slice i
//  rd_data      out  NUM_RD*DATA_W   read data, port i = slice i
//  rd_busy      out  NUM_RD          1 = register at rd_addr[i] has a pending producer
//  pc_in        in   DATA_W          current PC+8, returned for reads of PC_IDX
//  sb_set_en    in   1               mark sb_set_addr as pending (instruction issued)
//  sb_set_addr  in   ADDR_W          destination of the issued instruction
//  flush        in   1               clear every busy bit (pipeline flush)
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers clear to 0 and all busy bits clear to 0.
//    rd_data then reads 0, or pc_in for PC_IDX; rd_busy reads 0.
//  - Write: on posedge with wr_en=1 and wr_addr!=PC_IDX, reg[wr_addr] <= wr_data.
//    Writes to PC_IDX are dropped. Writes to wr_addr>=NUM_REGS are dropped.
//  - Read: combinational, 0-cycle latency.
//    rd_data[i] = (rd_addr[i]==PC_IDX) ? pc_in : reg[rd_addr[i]].
//    Out-of-range address reads 0.
//  - Busy set: on posedge with sb_set_en=1, busy[sb_set_addr] <= 1.
//    Ignored for PC_IDX and for out-of-range addresses.
//  - Busy clear: on posedge with wr_en=1, busy[wr_addr] <= 0.
//  - Busy priority per bit, highest first: flush (clear all) > set > clear.
//    Same-cycle set and write to one address leaves busy=1, because the new producer supersedes.
//  - rd_busy[i] = busy[rd_addr[i]]; always 0 for PC_IDX.
//  - Multiple read ports may share an address; each port is independent.
//  - Reset asserted mid-operation discards any write or set in progress.
//    State is valid again on the first posedge after rst_n rises.
// CONFIGURATION
//  Macro REG_FILE_SB_BYPASS_EN, optional feature:
//  - Defined: write-to-read forwarding.
//    If wr_en=1 and wr_addr==rd_addr[i]!=PC_IDX, then rd_data[i]=wr_data in the same cycle.
//    rd_busy[i]=0 in that case, unless sb_set_en targets the same address the same cycle.
//  - Undefined: rd_data[i] returns the stored (old) value until the edge.
//    rd_busy[i] reflects the stored busy bit only.
// STRUCTURE
//  - Package reg_file_sb_pkg: localparam DEFAULT_DATA_W=32 and DEFAULT_NUM_REGS=16.
//    Also holds localparam REG_PC=15 and typedefs reg_addr_t and reg_data_t.
//  - Sub-module reg_file_scoreboard owns the busy vector and the set/clear/flush priority.
//    It exposes busy[NUM_REGS-1:0].
//    The top level owns storage, PC muxing, read muxes and optional bypass.
// TESTING
//  1. rst_n=0 with regs preloaded -> all rd_data=0 and rd_busy=0 immediately, without waiting for clk.
//  2. wr_en=1, wr_addr=3, wr_data=32'hDEAD_BEEF; rd_addr[0]=3.
//     Without macro: old value in-cycle, 32'hDEAD_BEEF after the edge.
//     With macro: 32'hDEAD_BEEF in-cycle.
//  3. wr_en=1, wr_addr=15, wr_data=32'h1234; pc_in=32'h0000_0108; rd_addr[1]=15
//     -> rd_data[1]=32'h0000_0108 before and after the edge.
//  4. sb_set_en=1, sb_set_addr=5 -> rd_busy=1 next cycle for rd_addr=5.
//     Then wr_en=1, wr_addr=5 -> busy=0 after that edge.
//     Set and write on 5 in the same cycle -> busy stays 1.
//  5. Set busy on 1, 2 and 7, then flush=1 with sb_set_en=1, sb_set_addr=4 -> all busy=0 after the edge, including 4.
//  6. NUM_RD=3: all ports read 9 while reg[9]=32'hFFFF_FFFF
//     -> all three rd_data=32'hFFFF_FFFF and rd_busy identical on every port.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and types for the decode-stage register file.
package reg_file_sb_pkg;
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_NUM_REGS = 16;
   localparam int REG_PC = 15;
   typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;
   typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: per-register busy bits; flush beats set, set beats clear.
import reg_file_sb_pkg::*;
module reg_file_scoreboard #(
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int ADDR_W = $clog2(NUM_REGS),
   parameter int PC_IDX = REG_PC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_en,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_en,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic              flush,
   output logic [NUM_REGS-1:0] busy
);
   logic [NUM_REGS-1:0] busy_nxt;
   always_comb begin
      busy_nxt = busy;
      for (int r = 0; r < NUM_REGS; r++)
         busy_nxt[r] = flush ? 1'b0 :
                       (set_en && set_addr == ADDR_W'(r) && r != PC_IDX) ? 1'b1 :
                       (clr_en && clr_addr == ADDR_W'(r)) ? 1'b0 : busy[r];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) busy <= '0;
      else busy <= busy_nxt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with live-PC reads and busy scoreboard.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle writes to the read ports.
import reg_file_sb_pkg::*;
module reg_file_sb #(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int NUM_REGS = DEFAULT_NUM_REGS,
   parameter int NUM_RD = 2,
   parameter int PC_IDX = REG_PC,
   parameter int ADDR_W = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [DATA_W-1:0]        pc_in,
   input  logic                     sb_set_en,
   input  logic [ADDR_W-1:0]        sb_set_addr,
   input  logic                     flush
);
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);
   localparam logic [ADDR_W:0] N_A = (ADDR_W+1)'(NUM_REGS);
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic wr_ok;
   assign wr_ok = wr_en && wr_addr != PC_A && {1'b0, wr_addr} < N_A;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      else if (wr_ok) regs[wr_addr] <= wr_data;
   reg_file_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .PC_IDX(PC_IDX)) u_sb (
      .clk(clk), .rst_n(rst_n), .set_en(sb_set_en), .set_addr(sb_set_addr),
      .clr_en(wr_en), .clr_addr(wr_addr), .flush(flush), .busy(busy)
   );
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic pc_hit, in_rng, busy_s;
      logic [DATA_W-1:0] stored;
      assign addr = rd_addr[i*ADDR_W +: ADDR_W];
      assign pc_hit = addr == PC_A;
      assign in_rng = {1'b0, addr} < N_A;
      assign stored = pc_hit ? pc_in : in_rng ? regs[addr] : '0;
      assign busy_s = !pc_hit && in_rng && busy[addr];
`ifdef REG_FILE_SB_BYPASS_EN
      logic byp;
      // Forwarded value means the producer has retired, unless a new one issues now
      assign byp = wr_en && wr_addr == addr && !pc_hit && in_rng;
      assign rd_data[i*DATA_W +: DATA_W] = byp ? wr_data : stored;
      assign rd_busy[i] = byp ? (sb_set_en && sb_set_addr == addr) : busy_s;
`else
      assign rd_data[i*DATA_W +: DATA_W] = stored;
      assign rd_busy[i] = busy_s;
`endif
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed checks plus an array model compared every cycle.
module tb_reg_file_sb;
   localparam int NR = 3;
   logic clk = 0, rst_n = 0, wr_en = 0, sb_set_en = 0, flush = 0;
   logic [3:0] wr_addr = 0, sb_set_addr = 0;
   logic [31:0] wr_data = 0, pc_in = 0;
   logic [NR*4-1:0] rd_addr = 0;
   logic [NR*32-1:0] rd_data;
   logic [NR-1:0] rd_busy;
   int checks = 0, errors = 0;
   logic [31:0] mem [16];
   logic bsy [16];

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_W(32), .NUM_REGS(16), .NUM_RD(NR), .PC_IDX(15)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .pc_in(pc_in),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush)
   );

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int r = 0; r < 16; r++) begin
            mem[r] <= 0;
            bsy[r] <= 0;
         end
      end else begin
         if (wr_en && wr_addr != 15) mem[wr_addr] <= wr_data;
         if (flush) begin
            for (int r = 0; r < 16; r++) bsy[r] <= 0;
         end else begin
            if (wr_en) bsy[wr_addr] <= 0;
            if (sb_set_en && sb_set_addr != 15) bsy[sb_set_addr] <= 1;
         end
      end

   function automatic logic [31:0] exp_data(input logic [3:0] a);
      if (a == 15) return pc_in;
`ifdef REG_FILE_SB_BYPASS_EN
      if (wr_en && wr_addr == a) return wr_data;
`endif
      return mem[a];
   endfunction

   function automatic logic exp_busy(input logic [3:0] a);
      if (a == 15) return 1'b0;
`ifdef REG_FILE_SB_BYPASS_EN
      if (wr_en && wr_addr == a) return sb_set_en && sb_set_addr == a;
`endif
      return bsy[a];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (rst_n)
         for (int p = 0; p < NR; p++) begin
            chk($sformatf("model data port%0d", p), rd_data[p*32 +: 32], exp_data(rd_addr[p*4 +: 4]));
            chk($sformatf("model busy port%0d", p), 32'(rd_busy[p]), 32'(exp_busy(rd_addr[p*4 +: 4])));
         end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      wr_en = 1;
      for (int a = 0; a < 15; a++) begin
         wr_addr = 4'(a);
         wr_data = 32'hA000_0000 | a;
         tick;
      end
      wr_en = 0;
      sb_set_en = 1;
      sb_set_addr = 1;
      tick;
      sb_set_en = 0;
      rd_addr = {4'd9, 4'd3, 4'd1};
      #1;
      chk("preload r3", rd_data[63:32], 32'hA000_0003);
      chk("preload busy r1", 32'(rd_busy), 32'b001);
      // async reset must clear outputs without a clock edge
      rst_n = 0;
      #1;
      chk("reset data p0", rd_data[31:0], 32'h0);
      chk("reset data p1", rd_data[63:32], 32'h0);
      chk("reset data p2", rd_data[95:64], 32'h0);
      chk("reset busy", 32'(rd_busy), 32'h0);
      tick;
      rst_n = 1;
      wr_en = 1; wr_addr = 3; wr_data = 32'h1111_1111;
      tick;
      wr_data = 32'hDEAD_BEEF;
      rd_addr = {4'd0, 4'd0, 4'd3};
      #1;
`ifdef REG_FILE_SB_BYPASS_EN
      chk("r3 in-cycle", rd_data[31:0], 32'hDEAD_BEEF);
`else
      chk("r3 in-cycle", rd_data[31:0], 32'h1111_1111);
`endif
      tick;
      wr_en = 0;
      #1;
      chk("r3 after edge", rd_data[31:0], 32'hDEAD_BEEF);
      pc_in = 32'h0000_0108;
      wr_en = 1; wr_addr = 15; wr_data = 32'h1234;
      rd_addr = {4'd0, 4'd15, 4'd0};
      #1;
      chk("pc before edge", rd_data[63:32], 32'h0000_0108);
      tick;
      wr_en = 0;
      #1;
      chk("pc after edge", rd_data[63:32], 32'h0000_0108);
      chk("pc busy", 32'(rd_busy[1]), 32'h0);
      sb_set_en = 1; sb_set_addr = 5;
      rd_addr = {4'd0, 4'd15, 4'd5};
      #1;
      chk("busy5 before set", 32'(rd_busy[0]), 32'h0);
      tick;
      sb_set_en = 0;
      #1;
      chk("busy5 set", 32'(rd_busy[0]), 32'h1);
      wr_en = 1; wr_addr = 5; wr_data = 32'h55;
      #1;
`ifdef REG_FILE_SB_BYPASS_EN
      chk("busy5 in-cycle write", 32'(rd_busy[0]), 32'h0);
`else
      chk("busy5 in-cycle write", 32'(rd_busy[0]), 32'h1);
`endif
      tick;
      wr_en = 0;
      #1;
      chk("busy5 cleared", 32'(rd_busy[0]), 32'h0);
      wr_en = 1; sb_set_en = 1; wr_data = 32'h56;
      tick;
      wr_en = 0; sb_set_en = 0;
      #1;
      chk("busy5 set+write", 32'(rd_busy[0]), 32'h1);
      chk("r5 data", rd_data[31:0], 32'h56);
      sb_set_en = 1; sb_set_addr = 15;
      tick;
      sb_set_en = 0;
      #1;
      chk("pc never busy", 32'(rd_busy[1]), 32'h0);
      sb_set_en = 1;
      foreach (mem[k]) if (k == 1 || k == 2 || k == 7) begin
         sb_set_addr = 4'(k);
         tick;
      end
      sb_set_en = 0;
      rd_addr = {4'd7, 4'd2, 4'd1};
      #1;
      chk("busy 1/2/7", 32'(rd_busy), 32'b111);
      flush = 1; sb_set_en = 1; sb_set_addr = 4;
      tick;
      flush = 0; sb_set_en = 0;
      #1;
      chk("flush 1/2/7", 32'(rd_busy), 32'b000);
      rd_addr = {4'd5, 4'd2, 4'd4};
      #1;
      chk("flush beats set 4", 32'(rd_busy[0]), 32'h0);
      chk("flush clears 5", 32'(rd_busy[2]), 32'h0);
      wr_en = 1; wr_addr = 9; wr_data = 32'hFFFF_FFFF;
      sb_set_en = 1; sb_set_addr = 9;
      tick;
      wr_en = 0; sb_set_en = 0;
      rd_addr = {4'd9, 4'd9, 4'd9};
      #1;
      for (int p = 0; p < NR; p++)
         chk($sformatf("r9 port%0d", p), rd_data[p*32 +: 32], 32'hFFFF_FFFF);
      chk("r9 busy all ports", 32'(rd_busy), 32'b111);
      for (int a = 0; a < 8; a++) begin
         wr_en = a[0]; wr_addr = 4'(a + 2); wr_data = 32'h0BAD_0000 + a;
         sb_set_en = a[1]; sb_set_addr = 4'(a + 3);
         rd_addr = {4'(a + 3), 4'(a + 2), 4'(15 - a)};
         tick;
      end
      wr_en = 0; sb_set_en = 0;
      repeat (2) tick;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
